// File: rtl/bus_rr_arbiter.sv
// N-master to 1-slave round-robin arbiter for the req/gnt/data bus.
// Optional grant locking with a bounded hold time before forced rotation.
module bus_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int DATA_W      = 8,
   parameter bit LOCK_GRANT  = 1'b1,
   parameter int MAX_HOLD    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_data,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic                          s_req,
   input  logic                          s_gnt,
   output logic [DATA_W-1:0]             s_data,
   output logic [$clog2(NUM_MASTERS)-1:0] owner,
   output logic                          busy
);

   localparam int N  = NUM_MASTERS;
   localparam int OW = $clog2(N);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HLIM = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [OW-1:0]   ptr;
   logic [HW-1:0]   hcnt;
   logic [N-1:0]    others;
   logic [OW-1:0]   nxt;
   logic [OW-1:0]   pick_idle;
   logic [OW-1:0]   pick_next;
   logic            own_req;
   logic            beat;
   logic            hold_hit;
   logic            rel;

   // first set bit of mask, scanning upward from start with wrap
   function automatic logic [OW-1:0] sel(
      input logic [OW-1:0] start,
      input logic [N-1:0]  mask
   );
      logic [OW-1:0] r;
      int            idx;
      r = start;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % N;
         if (mask[idx]) r = OW'(idx);
      end
      return r;
   endfunction

   function automatic logic [N-1:0] onehot(input logic [OW-1:0] i);
      return N'(1) << i;
   endfunction

   always_comb begin
      own_req   = m_req[owner];
      beat      = (state == GRANT) && own_req && s_gnt;
      others    = m_req & ~onehot(owner);
      nxt       = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
      pick_idle = sel(ptr, m_req);
      pick_next = sel(nxt, others);
      hold_hit  = LOCK_GRANT && (MAX_HOLD > 0) && (hcnt >= HLIM);
      rel       = !own_req ||
                  (beat && (|others) && (!LOCK_GRANT || hold_hit));
   end

   assign busy   = (state == GRANT);
   assign s_req  = busy && own_req;
   assign s_data = s_req ? m_data[int'(owner)*DATA_W +: DATA_W] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         m_gnt <= '0;
         owner <= '0;
         ptr   <= '0;
         hcnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|m_req) begin
                  owner <= pick_idle;
                  m_gnt <= onehot(pick_idle);
                  hcnt  <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr <= nxt;
                  // hand over without an idle cycle when someone waits
                  if (|others) begin
                     owner <= pick_next;
                     m_gnt <= onehot(pick_next);
                     hcnt  <= '0;
                  end else begin
                     m_gnt <= '0;
                     state <= IDLE;
                  end
               end else if (beat && hcnt != HMAX) begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: three configurations share stimulus,
// a rule-level reference model queues expectations, monitors compare.
module tb_bus_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int ND = 3;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic [N-1:0]   m_req  = '0;
   logic [N*W-1:0] m_data = '0;
   logic           s_gnt  = 1'b0;

   logic [N-1:0]   gnt   [ND];
   logic           sreq  [ND];
   logic [W-1:0]   sdata [ND];
   logic [1:0]     own   [ND];
   logic           bsy   [ND];

   always #5 clk = ~clk;

   // dut0: lock, hold 4; dut1: no lock; dut2: lock, unlimited hold
   for (genvar g = 0; g < ND; g++) begin : g_dut
      bus_rr_arbiter #(
         .NUM_MASTERS(N),
         .DATA_W     (W),
         .LOCK_GRANT (g == 1 ? 1'b0 : 1'b1),
         .MAX_HOLD   (g == 0 ? 4 : (g == 2 ? 0 : 16))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .m_req (m_req),
         .m_data(m_data),
         .m_gnt (gnt[g]),
         .s_req (sreq[g]),
         .s_gnt (s_gnt),
         .s_data(sdata[g]),
         .owner (own[g]),
         .busy  (bsy[g])
      );
   end

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         busy;
      logic [1:0]   owner;
   } reg_t;
   typedef struct packed {
      logic         sreq;
      logic [W-1:0] sdata;
   } cmb_t;
   typedef reg_t [ND-1:0] reg3_t;
   typedef cmb_t [ND-1:0] cmb3_t;

   reg3_t rq[$];
   cmb3_t cq[$];

   int checks = 0;
   int errors = 0;

   int mb [ND];
   int mo [ND];
   int mp [ND];
   int mh [ND];
   int wcnt [ND][N];
   logic [N-1:0] pg [ND];

   function automatic int lock_of(int d);
      return (d == 1) ? 0 : 1;
   endfunction

   function automatic int hold_of(int d);
      return (d == 0) ? 4 : ((d == 2) ? 0 : 16);
   endfunction

   function automatic int pick(int start, logic [N-1:0] mask);
      for (int k = 0; k < N; k++)
         if (mask[(start + k) % N]) return (start + k) % N;
      return start;
   endfunction

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h want %0h t=%0t",
                  nm, d, act, exp, $time);
      end
   endtask

   task automatic step(input logic [N-1:0] req, input logic sg,
                       input logic rst);
      reg3_t        er;
      cmb3_t        ec;
      logic         prev;
      logic         sr;
      logic         beat;
      logic         rel;
      logic [W-1:0] sd;
      logic [N-1:0] oth;
      int           o;
      @(negedge clk);
      prev   = rst_n;
      m_req  = req;
      s_gnt  = sg;
      m_data = $urandom;
      rst_n  = rst;
      for (int d = 0; d < ND; d++) begin
         o = mo[d];
         if (!rst || mb[d] == 0) begin
            sr = 1'b0;
            sd = '0;
         end else begin
            sr = req[o];
            sd = sr ? m_data[o*W +: W] : '0;
         end
         ec[d].sreq  = sr;
         ec[d].sdata = sd;
         if (!rst) begin
            mb[d] = 0; mo[d] = 0; mp[d] = 0; mh[d] = 0;
         end else if (mb[d] == 0) begin
            if (req != '0) begin
               mo[d] = pick(mp[d], req);
               mh[d] = 0;
               mb[d] = 1;
            end
         end else begin
            beat   = sr && sg;
            oth    = req;
            oth[o] = 1'b0;
            rel = !req[o] ||
                  (beat && oth != '0 && (lock_of(d) == 0 ||
                   (hold_of(d) > 0 && mh[d] >= hold_of(d) - 1)));
            if (rel) begin
               mp[d] = (o + 1) % N;
               if (oth != '0) begin
                  mo[d] = pick(mp[d], oth);
                  mh[d] = 0;
               end else begin
                  mb[d] = 0;
               end
            end else if (beat && mh[d] < hold_of(d)) begin
               mh[d]++;
            end
         end
         er[d].busy  = (mb[d] != 0);
         er[d].gnt   = (mb[d] != 0) ? (N'(1) << mo[d]) : '0;
         er[d].owner = 2'(mo[d]);
      end
      rq.push_back(er);
      cq.push_back(ec);
      if (prev && !rst) begin
         #1;
         for (int d = 0; d < ND; d++) begin
            chk("rst_gnt", d, 32'(gnt[d]), 0);
            chk("rst_busy", d, 32'(bsy[d]), 0);
            chk("rst_sreq", d, 32'(sreq[d]), 0);
            chk("rst_sdata", d, 32'(sdata[d]), 0);
            chk("rst_owner", d, 32'(own[d]), 0);
         end
      end
   endtask

   task automatic run(input logic [N-1:0] req, input logic sg, input int n);
      repeat (n) step(req, sg, 1'b1);
   endtask

   initial begin : mon_reg
      reg3_t er;
      for (int d = 0; d < ND; d++) pg[d] = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rq.size() > 0) begin
            er = rq.pop_front();
            for (int d = 0; d < ND; d++) begin
               chk("gnt", d, 32'(gnt[d]), 32'(er[d].gnt));
               chk("busy", d, 32'(bsy[d]), 32'(er[d].busy));
               if (er[d].busy) chk("owner", d, 32'(own[d]), 32'(er[d].owner));
               if (gnt[d] != pg[d] && gnt[d] != '0) begin
                  for (int i = 0; i < N; i++) begin
                     if (m_req[i] && !gnt[d][i]) begin
                        wcnt[d][i]++;
                        chk("fair", d, 32'(wcnt[d][i] > N), 0);
                     end
                  end
               end
               for (int i = 0; i < N; i++)
                  if (!rst_n || !m_req[i] || gnt[d][i]) wcnt[d][i] = 0;
               pg[d] = gnt[d];
            end
         end
      end
   end

   initial begin : mon_cmb
      cmb3_t ec;
      forever begin
         @(negedge clk);
         #2;
         if (cq.size() > 0) begin
            ec = cq.pop_front();
            for (int d = 0; d < ND; d++) begin
               chk("s_req", d, 32'(sreq[d]), 32'(ec[d].sreq));
               chk("s_data", d, 32'(sdata[d]), 32'(ec[d].sdata));
            end
         end
      end
   end

   initial begin : drive
      logic [N-1:0] r;
      logic         rs;
      for (int d = 0; d < ND; d++) begin
         mb[d] = 0; mo[d] = 0; mp[d] = 0; mh[d] = 0;
         for (int i = 0; i < N; i++) wcnt[d][i] = 0;
      end
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      run('0, 1'b0, 2);
      // single master, then a wrap check of the pointer
      run(4'b0100, 1'b1, 4);
      run(4'b0000, 1'b1, 2);
      run(4'b0101, 1'b0, 2);
      run(4'b0000, 1'b0, 2);
      // contention with handover chain
      run(4'b1011, 1'b1, 6);
      run(4'b1010, 1'b1, 3);
      run(4'b1001, 1'b1, 3);
      run(4'b0011, 1'b1, 3);
      run(4'b0000, 1'b1, 2);
      // hold limit, then stalled slave
      run(4'b0011, 1'b1, 20);
      run(4'b0011, 1'b0, 8);
      run(4'b0011, 1'b1, 6);
      run(4'b0000, 1'b0, 2);
      // rotation on beats, then lone master
      run(4'b0110, 1'b1, 10);
      run(4'b0100, 1'b1, 8);
      run(4'b0000, 1'b0, 2);
      // asynchronous reset during a beat of master 3
      run(4'b1000, 1'b1, 3);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      run(4'b1001, 1'b1, 4);
      run(4'b0000, 1'b0, 2);
      // randomised sticky requests
      r = '0;
      repeat (10000) begin
         for (int i = 0; i < N; i++) begin
            if (!r[i])
               r[i] = ($urandom % 3 == 0);
            else if ((gnt[0][i] || gnt[1][i] || gnt[2][i]) &&
                     $urandom % 4 == 0)
               r[i] = 1'b0;
         end
         rs = ($urandom % 1500 != 0);
         step(r, ($urandom % 4 != 0), rs);
      end
      run('0, 1'b0, 2);
      repeat (3) @(posedge clk);
      #3;
      chk("drain", 0, 32'(rq.size() + cq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the req/gnt/data bus.
- Each requester presents the master-side signals: req out, gnt in, data out. The arbiter drives one slave-side req/gnt/data port.
- Round-robin fairness, optional grant locking and a bounded hold time.
- Sits between several bus masters and one shared bus slave.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, legal range 2..16.
- DATA_W, 8: bus data width in bits.
- LOCK_GRANT, 1: 1 = owner keeps the grant while its req stays high; 0 = rotate after every beat when another master is waiting.
- MAX_HOLD, 16: with LOCK_GRANT=1, the maximum number of consecutive beats before a forced rotation if others are waiting. 0 = unlimited.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- m_req  input  NUM_MASTERS  per-master request.
- m_data  input  NUM_MASTERS*DATA_W  per-master data. Master i occupies bits [i*DATA_W +: DATA_W].
- m_gnt  output  NUM_MASTERS  registered one-hot grant.
- s_req  output  1  request to the slave.
- s_gnt  input  1  slave accept; a beat completes when s_req && s_gnt.
- s_data  output  DATA_W  data of the current owner.
- owner  output  $clog2(NUM_MASTERS)  index of the current owner; valid when busy=1.
- busy  output  1  state == GRANT.

Behaviour:
- Reset (async, rst_n=0):
  - m_gnt=0, s_req=0, s_data=0, owner=0, busy=0.
  - Priority pointer ptr=0, hold counter hcnt=0, state=IDLE.
  - Applies immediately, including mid-transfer. The first grant after reset release is no earlier than the first rising edge with rst_n=1.
- Selection function sel(ptr, mask): first asserted bit scanning ptr, ptr+1, … and wrapping from NUM_MASTERS-1 to 0.
- IDLE:
  - If |m_req: owner<=sel(ptr, m_req), m_gnt<=onehot(owner), hcnt<=0, go to GRANT.
  - Latency: req sampled high at edge k gives gnt high after edge k, i.e. 1 cycle.
- GRANT:
  - s_req = m_req[owner] (combinational). s_data = m_data[owner] when s_req, else 0.
  - A beat is s_req && s_gnt. On each beat, hcnt increments, saturating at MAX_HOLD.
  - others = m_req with bit[owner] cleared.
- Release conditions, evaluated each edge in GRANT:
  - (a) m_req[owner]==0.
  - (b) LOCK_GRANT=0, a beat occurs this cycle, and |others.
  - (c) LOCK_GRANT=1, MAX_HOLD>0, a beat occurs with hcnt==MAX_HOLD-1, and |others.
- On release:
  - ptr<=owner+1 mod NUM_MASTERS.
  - If |others: grant moves directly to sel(owner+1, others) at the same edge, with no idle cycle, and hcnt<=0.
  - Otherwise: m_gnt<=0 and state<=IDLE.
  - In case (c) with no others waiting, no release occurs; hcnt saturates and the owner keeps the grant.
- Grant stability: m_gnt changes only on the edges above and is never more than one-hot.
- A master dropping req without a beat simply releases the grant; no data beat is issued.
- s_gnt asserted while s_req=0 is ignored.
- A new request arriving in the same cycle as a release takes part in that cycle's selection.

Test Plan:
- Single master: m_req=4'b0100 held for 3 beats with s_gnt=1, then dropped.
  - Required: m_gnt=4'b0100 one cycle after req; owner=2; s_data follows m_data[2] for 3 beats; on the cycle after req drops, m_gnt=0, busy=0, and ptr=3.
- Contention (LOCK_GRANT=1, MAX_HOLD=0): m_req=4'b1011 held, s_gnt=1.
  - Required: master 0 owns until its req drops.
  - Then grant goes directly to 1, then 3, then wraps to 0, with no idle cycle between owners.
- Hold limit (MAX_HOLD=4): masters 0 and 1 both request continuously.
  - Required: grant alternates every 4 beats (0,1,0,1…).
  - If s_gnt is held low, there are no beats and no rotation.
- No-lock mode (LOCK_GRANT=0): masters 1 and 2 request.
  - Required: grant alternates 1,2,1,2 on each beat.
  - Alone with s_gnt=1, master 2 keeps the grant indefinitely.
- Mid-operation reset: drive rst_n low asynchronously between edges while master 3 owns during a beat.
  - Required: all outputs 0 immediately.
  - After release with m_req=4'b1001: master 0 is granted first (ptr=0).
- Wrap and stability: randomised m_req and s_gnt for 10k cycles.
  - Required: m_gnt is always zero or one-hot.
  - No requester waits more than NUM_MASTERS grant changes.
  - s_data always equals m_data[owner] whenever s_req=1.
